// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control path: ALU op codes,
// RV32I major opcodes and the five-phase FSM state encoding.
package cpu_pkg;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_SLT = 4'b0111;
  localparam logic [3:0] ALUOP_SRL = 4'b1000;
  localparam logic [3:0] ALUOP_SLL = 4'b1001;
  localparam logic [3:0] ALUOP_SRA = 4'b1010;
  localparam logic [3:0] ALUOP_XOR = 4'b1101;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // Opcodes that take their second ALU operand from the immediate
  function automatic logic uses_imm(input logic [6:0] opc);
    return (opc == OP_IALU) || (opc == OP_LW) || (opc == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU op decode from opcode, funct3 and funct7[5].
// Loads/stores always add (address calc), BEQ always subtracts (compare);
// unsupported opcodes produce AND (0000) so a NOP shows an all-zero op.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  // funct3 table for R and I-ALU; SUB only exists in R-type
  always_comb begin
    alu_op = ALUOP_AND;
    if (opcode == OP_LW || opcode == OP_SW) begin
      alu_op = ALUOP_ADD;
    end else if (opcode == OP_BEQ) begin
      alu_op = ALUOP_SUB;
    end else if (opcode == OP_R || opcode == OP_IALU) begin
      case (funct3)
        3'b000:  alu_op = (opcode == OP_R && funct7_5) ? ALUOP_SUB : ALUOP_ADD;
        3'b001:  alu_op = ALUOP_SLL;
        3'b010:  alu_op = ALUOP_SLT;
        3'b100:  alu_op = ALUOP_XOR;
        3'b101:  alu_op = funct7_5 ? ALUOP_SRA : ALUOP_SRL;
        3'b110:  alu_op = ALUOP_OR;
        3'b111:  alu_op = ALUOP_AND;
        default: alu_op = ALUOP_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Five-phase (IF/ID/EX/MEM/WB) control FSM. Latches the instruction in IF,
// resolves BEQ from the ALU zero flag at the end of EX, and drives Moore
// outputs decoded only from state and the latched instruction.
module multicycle_control
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        loadPC,
  output logic        PCSrc,
  output logic [2:0]  state
);

  logic [31:0] ir;
  logic        br_taken;
  logic [2:0]  state_nxt;
  logic [3:0]  dec_op;
  logic [6:0]  opc;

  assign opc = ir[6:0];

  // Register/immediate fields only matter to the datapath, not to control
  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  alu_decoder u_alu_decoder (
    .opcode   (opc),
    .funct3   (ir[14:12]),
    .funct7_5 (ir[30]),
    .alu_op   (dec_op)
  );

  // Fixed ring of phases, no stalls
  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF:    state_nxt = S_ID;
      S_ID:    state_nxt = S_EX;
      S_EX:    state_nxt = S_MEM;
      S_MEM:   state_nxt = S_WB;
      default: state_nxt = S_IF;
    endcase
  end

  // State, instruction latch and branch-resolution flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IF;
      ir       <= '0;
      br_taken <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IF) ir <= instr;
      // zero is only trusted at the end of EX; cleared going back into IF
      if (state == S_EX) br_taken <= (opc == OP_BEQ) && zero;
      if (state == S_WB) br_taken <= 1'b0;
    end
  end

  // Moore output decode; every strobe is a one-phase pulse
  always_comb begin
    alu_op   = 4'b0000;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    loadPC   = 1'b0;
    PCSrc    = 1'b0;
    if (state != S_IF) begin
      alu_op = dec_op;
      ALUSrc = uses_imm(opc);
    end
    if (state == S_MEM) begin
      MemRead  = (opc == OP_LW);
      MemWrite = (opc == OP_SW);
    end
    if (state == S_WB) begin
      RegWrite = (opc == OP_R) || (opc == OP_IALU) || (opc == OP_LW);
      MemToReg = (opc == OP_LW);
      loadPC   = 1'b1;
      PCSrc    = br_taken;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instructions plus a randomized
// instruction stream with random zero/reset, all compared every cycle
// against a phase-counter reference model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  alu_op;
  logic        ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, loadPC, PCSrc;
  logic [2:0]  state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .alu_op(alu_op), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .loadPC(loadPC), .PCSrc(PCSrc),
    .state(state)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // reference model: phase 0..4 of current instruction, latched word, branch flag
  int          ph   = 0;
  logic [31:0] mir  = '0;
  logic        mbr  = 1'b0;
  logic        live = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (phase %0d ir %08h)", tag, obs, exp, ph, mir);
    end
  endtask

  // expected ALU op by instruction semantics
  function automatic logic [3:0] alu_ref(input logic [31:0] w);
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    o = w[6:0]; f3 = w[14:12]; f7 = w[30];
    if (o == 7'h03 || o == 7'h23) return 4'h2;            // LW/SW: add
    if (o == 7'h63) return 4'h6;                          // BEQ: sub
    if (o != 7'h33 && o != 7'h13) return 4'h0;            // NOP
    case (f3)
      3'd0: return (o == 7'h33 && f7) ? 4'h6 : 4'h2;
      3'd1: return 4'h9;
      3'd2: return 4'h7;
      3'd4: return 4'hD;
      3'd5: return f7 ? 4'hA : 4'h8;
      3'd6: return 4'h1;
      default: return 4'h0;
    endcase
  endfunction

  task automatic check_outputs();
    logic [6:0] o;
    bit is_r, is_i, is_lw, is_sw;
    o = mir[6:0];
    is_r = (o == 7'h33); is_i = (o == 7'h13); is_lw = (o == 7'h03); is_sw = (o == 7'h23);
    chk("state",    {29'd0, state},  ph);
    chk("alu_op",   {28'd0, alu_op}, (ph == 0) ? 0 : alu_ref(mir));
    chk("ALUSrc",   {31'd0, ALUSrc}, (ph != 0) && (is_i || is_lw || is_sw));
    chk("MemRead",  {31'd0, MemRead},  (ph == 3) && is_lw);
    chk("MemWrite", {31'd0, MemWrite}, (ph == 3) && is_sw);
    chk("MemToReg", {31'd0, MemToReg}, (ph == 4) && is_lw);
    chk("RegWrite", {31'd0, RegWrite}, (ph == 4) && (is_r || is_i || is_lw));
    chk("loadPC",   {31'd0, loadPC},   (ph == 4));
    chk("PCSrc",    {31'd0, PCSrc},    (ph == 4) && mbr);
  endtask

  // one clock: check current outputs, apply inputs, advance model to next edge
  task automatic step(input logic r, input logic [31:0] w, input logic z);
    @(negedge clk);
    if (live) check_outputs();
    rst = r; instr = w; zero = z;
    if (!r) begin
      ph = 0; mir = '0; mbr = 1'b0; live = 1'b1;
    end else if (live) begin
      if (ph == 0) mir = w;
      if (ph == 2) mbr = (mir[6:0] == 7'h63) && z;
      if (ph == 4) mbr = 1'b0;
      ph = (ph + 1) % 5;
    end
  endtask

  // full instruction; instr is garbage outside IF, zero per-phase from mask
  task automatic run_instr(input logic [31:0] w, input logic [4:0] zmask);
    for (int p = 0; p < 5; p++)
      step(1'b1, (p == 0) ? w : $urandom, zmask[p]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  o;
    int k;
    w = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: begin o = 7'h33; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      1: o = 7'h13;
      2: o = 7'h03;
      3: o = 7'h23;
      4: o = 7'h63;
      default: begin
        o = 7'h7F;
        while (o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h63)
          o = 7'($urandom);
        w[14:12] = 3'b111;
      end
    endcase
    w[6:0] = o;
    return w;
  endfunction

  initial begin
    rst = 1'b0; instr = '0; zero = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    // directed instruction set
    run_instr(32'h40208033, 5'b11111);   // SUB, zero high throughout
    run_instr(32'h4030D093, 5'b00000);   // SRAI
    run_instr(32'h00500093, 5'b00000);   // ADDI
    run_instr(32'h0000A083, 5'b00000);   // LW
    run_instr(32'h0010A023, 5'b00000);   // SW
    run_instr(32'h00208463, 5'b00100);   // BEQ taken
    run_instr(32'h00208463, 5'b11011);   // BEQ, zero outside EX only
    run_instr(32'hFFFFFFFF, 5'b11111);   // NOP
    run_instr(32'h00208463, 5'b00100);   // taken BEQ ...
    run_instr(32'h00208463, 5'b00000);   // ... then not taken: flag must not persist
    // reset for 3 cycles while SW is in MEM
    step(1'b1, 32'h0010A023, 1'b0);
    step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b0);
    step(1'b0, $urandom, 1'b0);
    step(1'b0, $urandom, 1'b0);
    step(1'b0, $urandom, 1'b0);
    run_instr(32'h00500093, 5'b00000);
    run_instr(32'h00500093, 5'b00000);
    // random stream with occasional mid-instruction resets
    for (int n = 0; n < 1500; n++) begin
      logic r;
      r = ($urandom_range(0, 39) != 0);
      step(r, (ph == 0) ? rand_instr() : $urandom, 1'($urandom));
    end
    step(1'b1, 32'h0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
